// File: rtl/tone_pkg.sv
`default_nettype none
// tone_pkg: frequency word type and note constants shared by tone_gen and the key lookup.
package tone_pkg;

  localparam int FREQ_W = 9;

  typedef logic [FREQ_W-1:0] freq_t;

  localparam freq_t NOTE_OFF = freq_t'(0);
  localparam freq_t NOTE_A3  = freq_t'(220);
  localparam freq_t NOTE_B3  = freq_t'(247);
  localparam freq_t NOTE_C4  = freq_t'(262);
  localparam freq_t NOTE_D4  = freq_t'(294);
  localparam freq_t NOTE_E4  = freq_t'(330);
  localparam freq_t NOTE_F4  = freq_t'(349);
  localparam freq_t NOTE_G4  = freq_t'(392);
  localparam freq_t NOTE_A4  = freq_t'(440);

endpackage
`default_nettype wire

// File: rtl/phase_acc.sv
`default_nettype none
// phase_acc: modulo-HALF phase accumulator; wrap marks the cycle whose edge crosses HALF.
module phase_acc
  import tone_pkg::*;
#(
  parameter int HALF   = 25_000_000,
  parameter int STEP_W = 9,
  parameter int ACC_W  = $clog2(HALF) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [STEP_W-1:0] step,
  output logic [ACC_W-1:0]  acc,
  output logic              wrap
);

  localparam logic [ACC_W:0] HALF_S = (ACC_W+1)'(HALF);

  logic [ACC_W:0] sum;
  logic [ACC_W:0] wrapped;

  always_comb begin
    sum     = {1'b0, acc} + (ACC_W+1)'(step);
    wrapped = sum - HALF_S;
    wrap    = !clear && (sum >= HALF_S);
  end

  // The remainder survives the wrap, which keeps the long-term pitch exact.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (wrap) begin
      acc <= wrapped[ACC_W-1:0];
    end else begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// tone_gen: 50%-duty square-wave tone from a note frequency in Hz, with glitch-free
// pitch changes (a new note is adopted only while the output is low).
module tone_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int FREQ_W = tone_pkg::FREQ_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [FREQ_W-1:0] freq,
  output logic              tone,
  output logic              active,
  output logic [FREQ_W-1:0] cur_freq,
  output logic              period_pulse
);

  import tone_pkg::*;

  localparam int HALF  = CLK_HZ / 2;
  localparam int ACC_W = $clog2(HALF) + 1;
  localparam logic [FREQ_W-1:0] SILENT = FREQ_W'(NOTE_OFF);

  logic             adopt;
  logic             clear;
  logic             wrap;
  logic [ACC_W-1:0] phase;

  // Holding adoption until tone is low means a high phase always finishes at the old pitch.
  always_comb begin
    adopt = en && (freq != cur_freq) && !tone;
    clear = !en || adopt;
  end

  phase_acc #(
    .HALF   (HALF),
    .STEP_W (FREQ_W),
    .ACC_W  (ACC_W)
  ) u_phase_acc (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .step  (cur_freq),
    .acc   (phase),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      tone         <= 1'b0;
      active       <= 1'b0;
      cur_freq     <= SILENT;
      period_pulse <= 1'b0;
    end else if (adopt) begin
      cur_freq     <= freq;
      active       <= (freq != SILENT);
      period_pulse <= 1'b0;
    end else begin
      active       <= (cur_freq != SILENT);
      period_pulse <= wrap && !tone;
      if (wrap) begin
        tone <= !tone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (phase < ACC_W'(HALF));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tone_gen.sv
`default_nettype none
// tb_tone_gen: directed checks of tone_gen at CLK_HZ = 4400 (HALF = 2200).
module tb_tone_gen;

  localparam int FW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [FW-1:0] freq = '0;
  logic          tone;
  logic          active;
  logic [FW-1:0] cur_freq;
  logic          period_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  tone_gen #(
    .CLK_HZ (4400),
    .FREQ_W (FW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .freq         (freq),
    .tone         (tone),
    .active       (active),
    .cur_freq     (cur_freq),
    .period_pulse (period_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clears everything with en low, then presents f so that the next tick is the adoption edge.
  task automatic restart(input logic [FW-1:0] f);
    en   = 1'b0;
    freq = f;
    tick();
    en = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    freq  = tone_pkg::NOTE_A4;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({tone, active, period_pulse} !== 3'b000 || cur_freq !== '0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: tone=%b active=%b pulse=%b cur_freq=%0d, want all 0",
                 i, tone, active, period_pulse, cur_freq);
      end
    end
    reset = 1'b0;
    freq  = '0;
    tick();
  endtask

  task automatic test_steady_440();
    restart(tone_pkg::NOTE_A4);
    tick();  // adoption edge A
    n_checks++;
    if (cur_freq !== 9'd440 || active !== 1'b1 || tone !== 1'b0) begin
      n_fail++;
      $display("FAIL steady_adopt: cur_freq=%0d active=%b tone=%b, want 440 1 0",
               cur_freq, active, tone);
    end
    for (int t = 1; t <= 40; t++) begin
      logic exp_tone;
      logic exp_pulse;
      tick();
      exp_tone  = ((t / 5) % 2) == 1;
      exp_pulse = (t % 10) == 5;
      n_checks++;
      if (tone !== exp_tone || period_pulse !== exp_pulse) begin
        n_fail++;
        $display("FAIL steady_wave t=%0d: tone=%b pulse=%b, want %b %b",
                 t, tone, period_pulse, exp_tone, exp_pulse);
      end
    end
  endtask

  task automatic test_fractional();
    int pulses = 0;
    int run    = 0;
    int bad    = 0;
    int toggles = 0;
    logic prev;
    restart(tone_pkg::NOTE_B3);
    tick();
    prev = tone;
    for (int t = 1; t <= 4400; t++) begin
      tick();
      if (period_pulse === 1'b1) pulses++;
      run++;
      if (tone !== prev) begin
        if (toggles > 0 && run != 8 && run != 9) begin
          bad++;
          if (bad <= 3) $display("half-period of %0d cycles at t=%0d", run, t);
        end
        toggles++;
        run  = 0;
        prev = tone;
      end
    end
    n_checks++;
    if (pulses < 246 || pulses > 248) begin
      n_fail++;
      $display("FAIL frac_count: %0d period pulses, want 247 +/- 1", pulses);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL frac_halfperiod: %0d half-periods outside 8..9, want 0", bad);
    end
  endtask

  task automatic test_glitch_free();
    restart(tone_pkg::NOTE_A4);
    tick();  // A
    for (int t = 1; t <= 6; t++) tick();
    freq = tone_pkg::NOTE_A3;  // two cycles into the high phase
    for (int t = 7; t <= 10; t++) begin
      logic exp_tone;
      tick();
      exp_tone = (t < 10);
      n_checks++;
      if (tone !== exp_tone || cur_freq !== 9'd440) begin
        n_fail++;
        $display("FAIL glitch_hold t=%0d: tone=%b cur_freq=%0d, want %b 440",
                 t, tone, cur_freq, exp_tone);
      end
    end
    tick();  // t = 11
    n_checks++;
    if (cur_freq !== 9'd220 || tone !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_adopt: cur_freq=%0d tone=%b, want 220 0", cur_freq, tone);
    end
    for (int t = 12; t <= 41; t++) begin
      logic exp_tone;
      tick();
      exp_tone = (t >= 21 && t < 31) || (t >= 41);
      n_checks++;
      if (tone !== exp_tone || period_pulse !== (t == 21 || t == 41)) begin
        n_fail++;
        $display("FAIL glitch_220 t=%0d: tone=%b pulse=%b, want tone %b",
                 t, tone, period_pulse, exp_tone);
      end
    end
  endtask

  task automatic test_silence_freq0();
    restart(tone_pkg::NOTE_A4);
    tick();
    for (int t = 1; t <= 6; t++) tick();
    freq = tone_pkg::NOTE_OFF;
    for (int t = 7; t <= 10; t++) begin
      logic exp_tone;
      tick();
      exp_tone = (t < 10);
      n_checks++;
      if (tone !== exp_tone || active !== 1'b1) begin
        n_fail++;
        $display("FAIL sil0_sched t=%0d: tone=%b active=%b, want %b 1",
                 t, tone, active, exp_tone);
      end
    end
    for (int t = 11; t <= 30; t++) begin
      tick();
      n_checks++;
      if (tone !== 1'b0 || active !== 1'b0 || cur_freq !== '0 || period_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL sil0_quiet t=%0d: tone=%b active=%b cur_freq=%0d pulse=%b, want 0",
                 t, tone, active, cur_freq, period_pulse);
      end
    end
  endtask

  task automatic test_silence_en();
    restart(tone_pkg::NOTE_A4);
    tick();
    for (int t = 1; t <= 6; t++) tick();
    n_checks++;
    if (tone !== 1'b1) begin
      n_fail++;
      $display("FAIL silen_pre: tone=%b, want 1", tone);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (tone !== 1'b0 || cur_freq !== '0 || active !== 1'b0 || period_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL silen_off cyc%0d: tone=%b cur_freq=%0d active=%b pulse=%b, want 0",
                 i, tone, cur_freq, active, period_pulse);
      end
    end
  endtask

  task automatic test_reset_mid();
    restart(tone_pkg::NOTE_A4);
    tick();
    for (int t = 1; t <= 7; t++) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({tone, active, period_pulse} !== 3'b000 || cur_freq !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: tone=%b active=%b pulse=%b cur_freq=%0d, want 0",
               tone, active, period_pulse, cur_freq);
    end
    reset = 1'b0;
    tick();  // re-adoption
    n_checks++;
    if (cur_freq !== 9'd440 || tone !== 1'b0 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_adopt: cur_freq=%0d tone=%b active=%b, want 440 0 1",
               cur_freq, tone, active);
    end
    for (int t = 1; t <= 5; t++) begin
      tick();
      n_checks++;
      if (tone !== (t == 5) || period_pulse !== (t == 5)) begin
        n_fail++;
        $display("FAIL rstmid_rise t=%0d: tone=%b pulse=%b, want %b", t, tone, period_pulse, t == 5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady_440();
    test_fractional();
    test_glitch_free();
    test_silence_freq0();
    test_silence_en();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tone_gen.md
# tone_gen

Square-wave tone generator for the keyboard synthesizer. It consumes the 9-bit note frequency in Hz that the key lookup produces, and drives the speaker pin with a 50%-duty square wave at that frequency. Pitch comes from an exact fractional phase accumulator, so no divider is needed. The adopted frequency is also exported so the 7-segment display path shows the note actually sounding.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz. Must be even and ≥ 4 × 511.
- `FREQ_W`, default 9: frequency word width. Value 0 means silence.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high. Clears all state.
- `en` in 1: global enable. Low forces silence immediately.
- `freq` in FREQ_W: requested note frequency in Hz, sampled every cycle.
- `tone` out 1: square-wave output to the speaker.
- `active` out 1: high while a nonzero frequency is adopted and `en` is high.
- `cur_freq` out FREQ_W: frequency currently being generated, for display.
- `period_pulse` out 1: one-cycle pulse registered together with each 0→1 edge of `tone`.

## Operation
- Constants: `HALF = CLK_HZ/2`. Accumulator width `ACC_W = $clog2(HALF) + 1`.
- State: `acc`, `cur_freq`, `tone`.
- Per cycle when `en` = 1 and `cur_freq` ≠ 0:
  - `s = acc + cur_freq`.
  - If `s ≥ HALF`: `acc ← s − HALF`, `tone ← ~tone`.
  - Otherwise: `acc ← s`.
  - Since `cur_freq < HALF`, there is at most one toggle per cycle.
  - The remainder is kept, so the long-term frequency is exact: f rising edges per CLK_HZ cycles, ±1.
- Adoption of a new `freq` (`freq` ≠ `cur_freq`):
  - Evaluated on the registered `tone`.
  - If `tone` = 0: `cur_freq ← freq`, `acc ← 0` at this edge. The accumulate/toggle step is skipped on this edge.
  - If `tone` = 1: the request is held off. Adoption happens on the first edge where registered `tone` = 0, using `freq` as sampled at that edge.
  - Result: no runt high pulse. The high phase always completes at the old pitch.
- Silence:
  - When `freq` = 0 is adopted: `tone` stays 0, `acc` is held at 0, `active` = 0.
  - `en` = 0: at the next edge, `tone ← 0`, `acc ← 0`, `cur_freq ← 0`, `period_pulse ← 0`. This is immediate and does not wait for a falling edge.
- Priority: `reset` > `en` = 0 > adoption > accumulate.
- If `freq` changes every cycle while `tone` = 0, the block re-adopts each time and `tone` stays low. This is accepted behaviour.

## Timing
- Reset values:
  - `tone` = 0, `active` = 0, `cur_freq` = 0, `period_pulse` = 0.
  - `acc` = 0.
- Adoption latency: `freq` presented before edge A is loaded at edge A, and `cur_freq` is visible after A.
- First rise occurs at edge A + k, with k = ceil(HALF/f). `period_pulse` is high for the single cycle after A + k.
- Later half-periods are floor(HALF/f) or ceil(HALF/f) cycles, and the average is exact.
- `active` is registered: `active` = (`cur_freq` ≠ 0) & `en`, updated on the same edge as `cur_freq`.
- Reset or `en` dropped mid-tone: outputs reach reset values at that edge. Restart behaves as a fresh adoption from `acc` = 0.
- `freq` changes on the same edge that `tone` falls: registered `tone` is still 1 at that edge, so adoption occurs one edge later.

## Structure
- Package `tone_pkg` holds:
  - `FREQ_W`.
  - The `freq_t` typedef.
  - Note constants shared with the key lookup: `NOTE_A3` = 220, `NOTE_B3` = 247, `NOTE_C4` = 262, `NOTE_D4` = 294, `NOTE_E4` = 330, `NOTE_F4` = 349, `NOTE_G4` = 392, `NOTE_A4` = 440, `NOTE_OFF` = 0.
- Sub-module `phase_acc`:
  - Parameterised by `HALF`.
  - Inputs: `clk`, `reset`, `clear`, `step`.
  - Outputs: `acc` and a one-cycle `wrap` pulse.
  - `tone_gen` owns adoption, the tone flip-flop and the outputs.

## Test plan
All scenarios use `CLK_HZ` = 4400, so `HALF` = 2200.

- **Reset:** hold `reset` 3 cycles with `freq` = 440, `en` = 1. Required: `tone` = 0, `active` = 0, `cur_freq` = 0, `period_pulse` = 0 throughout.
- **Steady 440 Hz:** `freq` = 440, `en` = 1 from idle. Required:
  - `cur_freq` = 440 one edge later.
  - First rise 5 edges after adoption.
  - Then exactly 5 cycles high, 5 cycles low, repeating.
  - `period_pulse` every 10 cycles.
- **Fractional accuracy:** `freq` = 247 for 4400 cycles. Required: 247 ± 1 `period_pulse`s, every half-period 8 or 9 cycles.
- **Glitch-free change:** switch 440→220 two cycles into a high phase. Required:
  - High phase lasts the full 5 cycles.
  - `cur_freq` = 220 one edge after the fall.
  - Subsequent half-periods are 10 cycles.
- **Silence paths:**
  - `freq` → 0 mid-high. Required: `tone` falls on schedule, then stays 0 with `active` = 0.
  - `en` → 0 mid-high. Required: `tone` = 0 and `cur_freq` = 0 at the next edge.
- **Reset mid-tone:** assert `reset` for 1 cycle during a high phase at 440. Required: outputs at reset values next edge, then re-adoption and first rise 5 edges later.
